// File: rtl/axil_lsu_master.sv
// axil_lsu_master: single-outstanding AXI4-Lite initiator for the load-store unit.
// Optional watchdog on bus phases is compiled in with AXIL_MASTER_TIMEOUT_EN.
module axil_lsu_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ar_addr,
    output logic [31:0] ar_width,
    output logic        ar_valid,
    input  logic        ar_ready,
    input  logic [31:0] r_data,
    input  logic        r_valid,
    output logic        r_ready,
    output logic [31:0] aw_addr,
    output logic [1:0]  aw_port,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    output logic        w_valid,
    input  logic        w_ready,
    input  logic [1:0]  b_resp,
    input  logic        b_valid,
    output logic        b_ready
);
    typedef enum logic [2:0] {IDLE, AR, R, WR, B, RESP} state_t;
    state_t state, state_nx;
    logic        signed_q, aw_done, w_done, bad, accept, aw_hs, w_hs, timeout;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, load_data;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign accept = req_valid && req_ready;
    assign bad = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'd0);
    assign aw_hs = aw_valid && aw_ready;
    assign w_hs = w_valid && w_ready;
    assign load_data = size_q == 2'd0 ? {{24{signed_q && r_data[7]}}, r_data[7:0]} :
                       size_q == 2'd1 ? {{16{signed_q && r_data[15]}}, r_data[15:0]} : r_data;
    assign ar_addr = addr_q;
    assign aw_addr = addr_q;
    assign aw_port = 2'd0;
    assign w_data = wdata_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic [31:0] cnt;
    logic        in_bus;
    assign in_bus = state inside {AR, R, WR, B};
    assign timeout = in_bus && cnt == 32'(TIMEOUT_CYCLES - 1);
    // Restart on every state change so each bus phase gets its own budget.
    always_ff @(posedge clk)
        cnt <= (reset || state_nx != state || !in_bus) ? 32'd0 : cnt + 32'd1;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bad ? RESP : (req_wen ? WR : AR);
            AR:      if (ar_valid && ar_ready) state_nx = R;
            R:       if (r_valid) state_nx = RESP;
            WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = B;
            B:       if (b_valid) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
        if (timeout) state_nx = RESP;
    end

    // Handshake outputs are withheld in the expiring cycle so no transfer races the abort.
    always_comb begin
        req_ready = state == IDLE && !reset;
        ar_valid = state == AR && !timeout;
        r_ready = state == R && !timeout;
        aw_valid = state == WR && !aw_done && !timeout;
        w_valid = state == WR && !w_done && !timeout;
        b_ready = state == B && !timeout;
        resp_valid = state == RESP;
        ar_width = state == AR ? 32'd8 << size_q : 32'd0;
        w_strb = state != WR ? 4'b0000 : size_q == 2'd0 ? 4'b0001 : size_q == 2'd1 ? 4'b0011 : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= 32'd0;
            wdata_q <= 32'd0;
            size_q <= 2'd0;
            signed_q <= 1'b0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                wdata_q <= req_wdata;
                size_q <= req_size;
                signed_q <= req_signed;
                aw_done <= 1'b0;
                w_done <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (state_nx == RESP && state != RESP) begin
                resp_rdata <= (state == R && !timeout) ? load_data : 32'd0;
                resp_err <= state == R ? timeout : state == B ? (timeout || b_resp != 2'd0) : 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axil_lsu_master.sv
// tb_axil_lsu_master: transaction-level model plus delay-programmable responder.
module tb_axil_lsu_master;
`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic req_valid, req_ready, req_wen, req_signed;
    logic [1:0] req_size;
    logic [31:0] req_addr, req_wdata;
    logic resp_valid, resp_err;
    logic [31:0] resp_rdata, ar_addr, ar_width, r_data, aw_addr, w_data;
    logic ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [1:0] aw_port, b_resp;
    logic [3:0] w_strb;

    int cyc = 0, n_cmp = 0, n_fail = 0;
    bit chk_en = 1'b1;
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rd_val = 32'd0;
    logic [1:0] br_val = 2'd0;
    logic [31:0] last_ar_width = 32'd0, last_wdata = 32'd0;
    logic [3:0] last_strb = 4'd0;

    axil_lsu_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ar_addr(ar_addr), .ar_width(ar_width), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
        .aw_addr(aw_addr), .aw_port(aw_port), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        if (sz == 2'd2) return d;
        v = sz == 2'd0 ? d % 32'd256 : d % 32'd65536;
        if (sg && sz == 2'd0 && v >= 32'd128) v = v - 32'd256;
        if (sg && sz == 2'd1 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    // Responder: each ready/valid rises after its programmed number of wait cycles (0 = held high).
    initial begin
        int ac = 0, rc = 0, awc = 0, wc = 0, bc = 0;
        ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0; r_data = 0; b_resp = 0;
        forever begin
            @(negedge clk);
            ac = ar_valid ? ac + 1 : 0;
            rc = r_ready ? rc + 1 : 0;
            awc = aw_valid ? awc + 1 : 0;
            wc = w_valid ? wc + 1 : 0;
            bc = b_ready ? bc + 1 : 0;
            @(posedge clk);
            #1;
            ar_ready = ar_dly == 0 || ac >= ar_dly;
            r_valid = r_dly == 0 || rc >= r_dly;
            aw_ready = aw_dly == 0 || awc >= aw_dly;
            w_ready = w_dly == 0 || wc >= w_dly;
            b_valid = b_dly == 0 || bc >= b_dly;
            r_data = rd_val;
            b_resp = br_val;
        end
    end

    // Transaction model: which channel the pending request must be on, and what it must return.
    bit pend = 0, bad_m = 0, wen_m = 0, sg_m = 0, ard = 0, rd = 0, awd = 0, wd = 0, bd = 0, hexp = 0, er_e = 0;
    logic [1:0] sz_m = 2'd0;
    logic [31:0] ad_m = 0, wd_m = 0, er_d = 0;
    always @(negedge clk) begin
        if (reset || !chk_en) begin
            if (reset) chk1("req_ready_in_reset", req_ready, 1'b0);
            pend = 0;
            hexp = 0;
        end else begin
            chk1("req_ready", req_ready, !pend);
            chk1("ar_valid", ar_valid, pend && !bad_m && !wen_m && !ard);
            chk1("r_ready", r_ready, pend && !bad_m && !wen_m && ard && !rd);
            chk1("aw_valid", aw_valid, pend && !bad_m && wen_m && !awd);
            chk1("w_valid", w_valid, pend && !bad_m && wen_m && !wd);
            chk1("b_ready", b_ready, pend && !bad_m && wen_m && awd && wd && !bd);
            chk1("resp_valid", resp_valid, hexp);
            if (ar_valid) begin
                chk("ar_addr", ar_addr, ad_m);
                chk("ar_width", ar_width, 32'd8 << sz_m);
                last_ar_width = ar_width;
            end
            if (aw_valid) begin
                chk("aw_addr", aw_addr, ad_m);
                chk("aw_port", {30'd0, aw_port}, 32'd0);
            end
            if (w_valid) begin
                chk("w_data", w_data, wd_m);
                chk("w_strb", {28'd0, w_strb}, (32'd1 << (32'd1 << sz_m)) - 32'd1);
                last_strb = w_strb;
                last_wdata = w_data;
            end
            if (resp_valid && hexp) begin
                chk("resp_rdata", resp_rdata, er_d);
                chk1("resp_err", resp_err, er_e);
                pend = 0;
                hexp = 0;
            end
            if (ar_valid && ar_ready) ard = 1;
            if (r_ready && r_valid) begin
                rd = 1; hexp = 1; er_d = model_load(r_data, sz_m, sg_m); er_e = 0;
            end
            if (aw_valid && aw_ready) awd = 1;
            if (w_valid && w_ready) wd = 1;
            if (b_ready && b_valid) begin
                bd = 1; hexp = 1; er_d = 0; er_e = b_resp != 2'd0;
            end
            if (req_valid && req_ready) begin
                pend = 1; wen_m = req_wen; sz_m = req_size; sg_m = req_signed; ad_m = req_addr; wd_m = req_wdata;
                bad_m = sz_m == 2'd3 || (sz_m == 2'd1 && ad_m % 2 != 0) || (sz_m == 2'd2 && ad_m % 4 != 0);
                ard = 0; rd = 0; awd = 0; wd = 0; bd = 0;
                hexp = bad_m; er_d = 0; er_e = 1;
            end
        end
    end

    task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
        ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    task automatic run_req(input logic wen, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                           input logic [31:0] wdat, output logic [31:0] rdata, output logic err, output int lat);
        int n, a;
        @(posedge clk);
        #1;
        req_valid = 1; req_wen = wen; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wdat;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("accepted", req_ready, 1'b1);
        a = cyc;
        @(posedge clk);
        #1;
        req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk1("resp_seen", resp_valid, 1'b1);
        rdata = resp_rdata;
        err = resp_err;
        lat = cyc - a;
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        logic [31:0] rdv, addr;
        logic er;
        int lat;
        logic [1:0] sz;
        req_valid = 0; req_wen = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_ar_valid", ar_valid, 1'b0);
        chk1("rst_aw_w_valid", aw_valid || w_valid, 1'b0);
        chk1("rst_readies", r_ready || b_ready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk("rst_w_strb", {28'd0, w_strb}, 32'd0);

        set_dly(1, 2, 0, 0, 0);
        rd_val = 32'hDEAD_BEEF;
        run_req(0, 2, 0, 32'h8000_0000, 0, rdv, er, lat);
        chk("lw_rdata", rdv, 32'hDEAD_BEEF);
        chk1("lw_err", er, 1'b0);
        chk("lw_latency", lat, 6);
        chk("lw_ar_width", last_ar_width, 32'd32);

        set_dly(0, 0, 0, 0, 0);
        run_req(0, 2, 0, 32'h8000_0004, 0, rdv, er, lat);
        chk("lw_fast_latency", lat, 3);
        rd_val = 32'h0000_0080;
        run_req(0, 0, 1, 32'hA000_0003, 0, rdv, er, lat);
        chk("lb_signed", rdv, 32'hFFFF_FF80);
        run_req(0, 0, 0, 32'hA000_0003, 0, rdv, er, lat);
        chk("lb_unsigned", rdv, 32'h0000_0080);
        rd_val = 32'h0000_7FFF;
        run_req(0, 1, 1, 32'hA000_0002, 0, rdv, er, lat);
        chk("lh_signed_pos", rdv, 32'h0000_7FFF);
        rd_val = 32'h5555_8001;
        run_req(0, 1, 1, 32'hA000_0002, 0, rdv, er, lat);
        chk("lh_signed_neg", rdv, 32'hFFFF_8001);

        set_dly(0, 0, 3, 0, 0);
        run_req(1, 1, 0, 32'hA000_03F8, 32'h0000_1234, rdv, er, lat);
        chk("sh_strb", {28'd0, last_strb}, 32'h3);
        chk("sh_wdata", last_wdata, 32'h0000_1234);
        chk1("sh_err", er, 1'b0);
        chk("sh_latency", lat, 6);
        set_dly(0, 0, 0, 0, 0);
        run_req(1, 2, 0, 32'hA000_0400, 32'hCAFE_F00D, rdv, er, lat);
        chk("sw_fast_latency", lat, 3);
        br_val = 2'b10;
        run_req(1, 2, 0, 32'hA000_0404, 32'h1, rdv, er, lat);
        chk1("sw_berr", er, 1'b1);
        chk("sw_berr_rdata", rdv, 32'd0);
        br_val = 2'b00;

        run_req(0, 2, 0, 32'h8000_0002, 0, rdv, er, lat);
        chk1("mis_word_err", er, 1'b1);
        chk("mis_word_latency", lat, 1);
        run_req(0, 3, 0, 32'h8000_0000, 0, rdv, er, lat);
        chk1("size3_err", er, 1'b1);
        chk("size3_latency", lat, 1);
        run_req(1, 1, 0, 32'h8000_0001, 0, rdv, er, lat);
        chk1("mis_half_store_err", er, 1'b1);

        set_dly(0, 0, 0, 30, 0);
        @(posedge clk);
        #1;
        req_valid = 1; req_wen = 1; req_size = 2; req_addr = 32'h100; req_wdata = 32'h77;
        @(negedge clk);
        chk1("rstwr_accept", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk1("rstwr_aw_done", aw_valid, 1'b0);
        chk1("rstwr_w_pending", w_valid, 1'b1);
        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk1("rstwr_valids_clear", aw_valid || w_valid || ar_valid || b_ready || r_ready || resp_valid, 1'b0);
        chk1("rstwr_req_ready", req_ready, 1'b1);

`ifdef AXIL_MASTER_TIMEOUT_EN
        chk_en = 0;
        set_dly(1000, 0, 0, 0, 0);
        run_req(0, 2, 0, 32'h40, 0, rdv, er, lat);
        chk1("timeout_err", er, 1'b1);
        chk("timeout_rdata", rdv, 32'd0);
        chk("timeout_latency", lat, 9);
        @(posedge clk);
        #1 chk_en = 1;
`endif

        for (int i = 0; i < 300; i++) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
            rd_val = $urandom;
            br_val = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
            sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                if (sz == 2'd1) addr[0] = 1'b0;
                if (sz == 2'd2) addr[1:0] = 2'b00;
            end
            run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, rdv, er, lat);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
